// File: rtl/qpmm_sched_if.sv
// Job request and RAM-port bundle between a QPMM job controller and qpmm_sched.
// The master side issues jobs; the slave side (the scheduler) drives RAM addresses and status.
interface qpmm_sched_if #(
  parameter int AW    = 9,
  parameter int CNT_W = 10
);
  logic             start;
  logic [AW-1:0]    a_base;
  logic [AW-1:0]    b_base;
  logic [AW-1:0]    z_base;
  logic [CNT_W-1:0] len;
  logic             hold;
  logic [AW-1:0]    ra_addr;
  logic [AW-1:0]    rb_addr;
  logic [AW-1:0]    wz_addr;
  logic             wz_en;
  logic             busy;
  logic             done;

  modport master (
    output start, a_base, b_base, z_base, len, hold,
    input  ra_addr, rb_addr, wz_addr, wz_en, busy, done
  );

  modport slave (
    input  start, a_base, b_base, z_base, len, hold,
    output ra_addr, rb_addr, wz_addr, wz_en, busy, done
  );
endinterface

// File: rtl/qpmm_sched.sv
// Issues operand RAM reads for a QPMM job and writes results back in issue order after RD_LAT+MUL_LAT.
// Optional QPMM_SCHED_PERF_EN adds perf_cycles, a saturating start-to-done cycle counter.
module qpmm_sched #(
  parameter int AW      = 9,
  parameter int CNT_W   = 10,
  parameter int RD_LAT  = 3,
  parameter int MUL_LAT = 36
) (
  input  logic         clk,
  input  logic         rstn,
  qpmm_sched_if.slave  bus
`ifdef QPMM_SCHED_PERF_EN
  ,
  output logic [31:0]  perf_cycles
`endif
);
  localparam int D = RD_LAT + MUL_LAT;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    a_base_q, a_base_d, b_base_q, b_base_d, z_base_q, z_base_d;
  logic [CNT_W-1:0] len_q, len_d, i_q, i_d, r_q, r_d;
  logic [D-1:0]     vsr_q, vsr_d;
  logic [AW-1:0]    ra_addr_q, ra_addr_d, rb_addr_q, rb_addr_d, wz_addr_q, wz_addr_d;
  logic             wz_en_q, wz_en_d, busy_q, busy_d, done_q, done_d;
  logic             retire;

  always_comb begin
    state_d   = state_q;
    a_base_d  = a_base_q;
    b_base_d  = b_base_q;
    z_base_d  = z_base_q;
    len_d     = len_q;
    i_d       = i_q;
    r_d       = r_q;
    ra_addr_d = ra_addr_q;
    rb_addr_d = rb_addr_q;
    wz_addr_d = wz_addr_q;
    vsr_d     = vsr_q << 1;
    retire    = vsr_q[D-1];
    wz_en_d   = retire;

    // Retire runs independently of the FSM so it can coincide with an issue.
    if (retire) begin
      wz_addr_d = z_base_q + AW'(r_q);
      r_d       = r_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_base_d = bus.a_base;
          b_base_d = bus.b_base;
          z_base_d = bus.z_base;
          len_d    = bus.len;
          i_d      = '0;
          r_d      = '0;
          state_d  = (bus.len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.hold) begin
          ra_addr_d = a_base_q + AW'(i_q);
          rb_addr_d = b_base_q + AW'(i_q);
          vsr_d[0]  = 1'b1;
          i_d       = i_q + CNT_W'(1);
          if ((i_q + CNT_W'(1)) == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (r_q == len_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      a_base_q  <= '0;
      b_base_q  <= '0;
      z_base_q  <= '0;
      len_q     <= '0;
      i_q       <= '0;
      r_q       <= '0;
      vsr_q     <= '0;
      ra_addr_q <= '0;
      rb_addr_q <= '0;
      wz_addr_q <= '0;
      wz_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_base_q  <= a_base_d;
      b_base_q  <= b_base_d;
      z_base_q  <= z_base_d;
      len_q     <= len_d;
      i_q       <= i_d;
      r_q       <= r_d;
      vsr_q     <= vsr_d;
      ra_addr_q <= ra_addr_d;
      rb_addr_q <= rb_addr_d;
      wz_addr_q <= wz_addr_d;
      wz_en_q   <= wz_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.ra_addr = ra_addr_q;
  assign bus.rb_addr = rb_addr_q;
  assign bus.wz_addr = wz_addr_q;
  assign bus.wz_en   = wz_en_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

`ifdef QPMM_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Loaded with 1 on accept so the first busy cycle counts; frozen from DONE on.
  always_comb begin
    perf_d = perf_q;
    if (state_q == IDLE && bus.start) begin
      perf_d = 32'd1;
    end else if (state_q != IDLE && state_q != DONE && perf_q != '1) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif
endmodule

// File: doc/qpmm_sched.md
QPMM_SCHED -- requirements
Module: qpmm_sched

Interface
REQ-001 The block SHALL have parameter AW, default 9, meaning operand/result RAM address width.
REQ-002 The block SHALL have parameter CNT_W, default 10, meaning width of the job length field.
REQ-003 The block SHALL have parameter RD_LAT, default 3, meaning operand RAM read latency in cycles (addrb to doutb).
REQ-004 The block SHALL have parameter MUL_LAT, default 36, meaning QPMM_d0 latency in cycles (A/B to Z).
REQ-005 The block SHALL have port clk, input, 1, the single clock.
REQ-006 The block SHALL have port rstn, input, 1, the reset: asynchronous, active-low.
REQ-007 The block SHALL have port start, input, 1, job request; sampled only in IDLE.
REQ-008 The block SHALL have ports a_base, b_base and z_base, input, AW each, the job base addresses for operand A RAM, operand B RAM and result RAM.
REQ-009 The block SHALL have port len, input, CNT_W, the number of products in the job.
REQ-010 The block SHALL have port hold, input, 1, which suppresses issue in the cycle it is high.
REQ-011 The block SHALL have ports ra_addr and rb_addr, output, AW each, the operand RAM read addresses.
REQ-012 The block SHALL have port wz_addr, output, AW, the result RAM write address.
REQ-013 The block SHALL have port wz_en, output, 1, the result RAM write enable.
REQ-014 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-015 The block SHALL have port done, output, 1, a one-cycle job-completion pulse.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, DRAIN and DONE.
REQ-017 In IDLE with start=1, the block SHALL latch a_base, b_base, z_base and len, clear the issue and retire indices, and enter ISSUE; if len=0 it SHALL enter DONE instead.
REQ-018 Start SHALL be ignored in every state other than IDLE.
REQ-019 In ISSUE with hold=0, the block SHALL drive ra_addr=a_base+i and rb_addr=b_base+i, push a 1 into the valid shift register, and increment i.
REQ-020 In ISSUE with hold=1, the block SHALL push a 0 and keep the addresses unchanged.
REQ-021 When the len-th issue occurs, the block SHALL move from ISSUE to DRAIN in the next cycle.
REQ-022 The valid shift register SHALL be RD_LAT+MUL_LAT deep; a 1 leaving the final stage SHALL assert wz_en for exactly that cycle, with wz_addr=z_base+r, and r SHALL then increment.
REQ-023 Results SHALL retire in issue order, each exactly RD_LAT+MUL_LAT cycles after its issue cycle; hold gaps SHALL be preserved.
REQ-024 DRAIN SHALL go to DONE in the cycle after the len-th wz_en, and DONE SHALL go to IDLE after one cycle with done=1.
REQ-025 All address sums SHALL wrap modulo 2^AW with no error indication.
REQ-026 Issues and retires in the same cycle SHALL both take effect.
REQ-027 Outside ISSUE, ra_addr and rb_addr SHALL hold their last value.

Reset
REQ-028 With rstn=0, the block SHALL immediately enter IDLE and clear the shift register and indices.
REQ-029 With rstn=0, the block SHALL drive busy=0, done=0, wz_en=0, ra_addr=0, rb_addr=0 and wz_addr=0.
REQ-030 A reset during a job SHALL abandon it, and no wz_en SHALL follow the reset.

Configuration
REQ-031 With macro QPMM_SCHED_PERF_EN defined, the block SHALL add output perf_cycles[31:0], counting cycles from start acceptance to done inclusive (saturating) and held until the next accepted start; the reset value SHALL be 0.
REQ-032 Without QPMM_SCHED_PERF_EN, the perf_cycles port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Directed scenario: len=4, bases 0/0x10/0x20, hold=0 -> ra_addr 0..3 on consecutive cycles; wz_en at issue+39 for wz_addr 0x20..0x23; done one cycle after the last write.
REQ-034 Directed scenario: len=0, start -> busy high 1 cycle, done pulse, no wz_en; perf_cycles=1 with PERF_EN.
REQ-035 Directed scenario: len=3, hold high on the 2nd issue cycle -> write cycles offset by 0, 2 and 3 from the first write.
REQ-036 Directed scenario: a_base=0x1FE, z_base=0x1FF, len=3 -> ra_addr 0x1FE, 0x1FF, 0x000; wz_addr 0x1FF, 0x000, 0x001.
REQ-037 Directed scenario: start pulsed again in ISSUE -> ignored; latched bases unchanged.
REQ-038 Directed scenario: rstn low mid-DRAIN -> outputs zero at once, no further wz_en, and a new job after reset completes normally.
